// File: rtl/rpsc_fault_latch.sv
// Fault latch for the RF-permit card: per-channel debounce, sticky fault flops,
// first-fault capture, alarm drive and operator clear with a re-arm hold-off.
module rpsc_fault_latch #(
    parameter int N_FAULT         = 6,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int HOLDOFF_CYCLES  = 16
) (
    input  logic               clk,
    input  logic               reset_b,
    input  logic [N_FAULT-1:0] fault_in,
    input  logic               clr_req,
    output logic [N_FAULT-1:0] ff,
    output logic [N_FAULT-1:0] first_fault,
    output logic               alarm_b,
    output logic               armed,
    output logic               clr_ack,
    output logic               clr_nak,
    output logic [7:0]         trip_count
);

    typedef enum logic [1:0] {
        ST_ARMED   = 2'd0,
        ST_TRIPPED = 2'd1,
        ST_HOLDOFF = 2'd2
    } state_t;

    localparam logic [7:0]  DB_MAX  = 8'(DEBOUNCE_CYCLES);
    localparam logic [15:0] HO_LOAD = 16'(HOLDOFF_CYCLES - 1);

    state_t                      state_r, state_s;
    logic [15:0]                 ho_cnt_r, ho_cnt_s;
    logic [N_FAULT-1:0][7:0]     db_cnt_r, db_cnt_s;
    logic [N_FAULT-1:0]          qual_s;
    logic [N_FAULT-1:0]          ff_s, first_s;
    logic [7:0]                  trip_s;
    logic                        ack_s, nak_s;

    // Debounce: count consecutive high samples, qualify exactly once on the last one.
    always_comb begin
        db_cnt_s = db_cnt_r;
        qual_s   = {N_FAULT{1'b0}};
        for (int i = 0; i < N_FAULT; i++) begin
            if (fault_in[i]) begin
                if (db_cnt_r[i] != DB_MAX) begin
                    db_cnt_s[i] = db_cnt_r[i] + 8'd1;
                end else begin
                    db_cnt_s[i] = db_cnt_r[i];
                end
                qual_s[i] = (db_cnt_r[i] == (DB_MAX - 8'd1));
            end else begin
                db_cnt_s[i] = 8'd0;
                qual_s[i]   = 1'b0;
            end
        end
    end

    // Next-state, latch and clear handshake; a qualifying fault always beats a clear.
    always_comb begin
        state_s  = state_r;
        ho_cnt_s = ho_cnt_r;
        ff_s     = ff | qual_s;
        first_s  = first_fault;
        trip_s   = trip_count;
        ack_s    = 1'b0;
        nak_s    = 1'b0;
        case (state_r)
            ST_ARMED: begin
                if (|qual_s) begin
                    state_s = ST_TRIPPED;
                    first_s = qual_s;
                    if (trip_count != 8'hFF) begin
                        trip_s = trip_count + 8'd1;
                    end else begin
                        trip_s = trip_count;
                    end
                end else begin
                    state_s = ST_ARMED;
                end
            end
            ST_TRIPPED: begin
                if (clr_req) begin
                    if ((fault_in == {N_FAULT{1'b0}}) && (qual_s == {N_FAULT{1'b0}})) begin
                        ack_s    = 1'b1;
                        ff_s     = {N_FAULT{1'b0}};
                        first_s  = {N_FAULT{1'b0}};
                        state_s  = ST_HOLDOFF;
                        ho_cnt_s = HO_LOAD;
                    end else begin
                        nak_s = 1'b1;
                    end
                end else begin
                    state_s = ST_TRIPPED;
                end
            end
            ST_HOLDOFF: begin
                // A re-trip during hold-off is part of the same clear cycle: not counted again.
                if (|qual_s) begin
                    state_s = ST_TRIPPED;
                    first_s = qual_s;
                end else if (ho_cnt_r == 16'd0) begin
                    state_s = ST_ARMED;
                end else begin
                    ho_cnt_s = ho_cnt_r - 16'd1;
                end
            end
            default: begin
                state_s  = ST_ARMED;
                ho_cnt_s = 16'd0;
            end
        endcase
    end

    // State and registered outputs with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_b) begin
            state_r     <= ST_ARMED;
            ho_cnt_r    <= 16'd0;
            db_cnt_r    <= '0;
            ff          <= {N_FAULT{1'b0}};
            first_fault <= {N_FAULT{1'b0}};
            alarm_b     <= 1'b1;
            armed       <= 1'b1;
            clr_ack     <= 1'b0;
            clr_nak     <= 1'b0;
            trip_count  <= 8'd0;
        end else begin
            state_r     <= state_s;
            ho_cnt_r    <= ho_cnt_s;
            db_cnt_r    <= db_cnt_s;
            ff          <= ff_s;
            first_fault <= first_s;
            alarm_b     <= ~|ff_s;
            armed       <= (state_s == ST_ARMED);
            clr_ack     <= ack_s;
            clr_nak     <= nak_s;
            trip_count  <= trip_s;
        end
    end

endmodule

// File: tb/tb_rpsc_fault_latch.sv
// Bench for rpsc_fault_latch: directed test-plan scenarios plus randomized traffic,
// all compared against a rule-level reference model.
module tb_rpsc_fault_latch;

    localparam int NF = 6;
    localparam int DB = 4;
    localparam int HO = 16;

    logic          clk = 1'b0;
    logic          reset_b;
    logic [NF-1:0] fault_in;
    logic          clr_req;
    logic [NF-1:0] ff, first_fault;
    logic          alarm_b, armed, clr_ack, clr_nak;
    logic [7:0]    trip_count;

    int errors = 0;
    int checks = 0;

    // reference model state
    int            run [NF];
    int            m_mode;   // 0 armed, 1 tripped, 2 hold-off
    int            m_ticks;
    logic [NF-1:0] m_ff, m_first;
    int            m_trips;
    bit            m_ack, m_nak;

    rpsc_fault_latch #(.N_FAULT(NF), .DEBOUNCE_CYCLES(DB), .HOLDOFF_CYCLES(HO)) dut (
        .clk(clk), .reset_b(reset_b), .fault_in(fault_in), .clr_req(clr_req),
        .ff(ff), .first_fault(first_fault), .alarm_b(alarm_b), .armed(armed),
        .clr_ack(clr_ack), .clr_nak(clr_nak), .trip_count(trip_count)
    );

    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Apply the rules to the inputs present at this clock edge.
    task automatic model_edge();
        logic [NF-1:0] q;
        q = '0;
        if (!reset_b) begin
            for (int i = 0; i < NF; i++) run[i] = 0;
            m_mode = 0; m_ticks = 0; m_ff = '0; m_first = '0; m_trips = 0;
            m_ack = 1'b0; m_nak = 1'b0;
        end else begin
            for (int i = 0; i < NF; i++) begin
                if (fault_in[i]) run[i] = (run[i] >= DB) ? DB + 1 : run[i] + 1;
                else run[i] = 0;
                q[i] = (run[i] == DB);
            end
            m_ack = 1'b0;
            m_nak = 1'b0;
            if (m_mode == 1 && clr_req) begin
                if (fault_in == '0) begin
                    m_ack = 1'b1; m_ff = '0; m_first = '0; m_mode = 2; m_ticks = 0;
                end else begin
                    m_nak = 1'b1; m_ff = m_ff | q;
                end
            end else if (m_mode == 0) begin
                m_ff = m_ff | q;
                if (q != '0) begin
                    m_mode = 1; m_first = q;
                    if (m_trips < 255) m_trips++;
                end
            end else if (m_mode == 2) begin
                if (q != '0) begin
                    m_mode = 1; m_ff = m_ff | q; m_first = q;
                end else begin
                    m_ticks++;
                    if (m_ticks == HO) m_mode = 0;
                end
            end else begin
                m_ff = m_ff | q;
            end
        end
    endtask

    task automatic compare_all();
        check_value("ff", 32'(ff), 32'(m_ff));
        check_value("first_fault", 32'(first_fault), 32'(m_first));
        check_value("alarm_b", 32'(alarm_b), 32'(m_ff == '0));
        check_value("armed", 32'(armed), 32'(m_mode == 0));
        check_value("clr_ack", 32'(clr_ack), 32'(m_ack));
        check_value("clr_nak", 32'(clr_nak), 32'(m_nak));
        check_value("trip_count", 32'(trip_count), 32'(m_trips));
    endtask

    task automatic tick(input logic rb, input logic [NF-1:0] fin, input logic clr);
        reset_b  = rb;
        fault_in = fin;
        clr_req  = clr;
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic clear_and_rearm();
        tick(1'b1, '0, 1'b0);
        tick(1'b1, '0, 1'b1);
        repeat (HO) tick(1'b1, '0, 1'b0);
    endtask

    initial begin
        logic [NF-1:0] target;
        logic [NF-1:0] drive;
        reset_b = 1'b0; fault_in = '0; clr_req = 1'b0;

        // reset held with all faults high, then release
        repeat (3) tick(1'b0, 6'h3F, 1'b0);
        check_value("rst_ff", 32'(ff), 32'h0);
        check_value("rst_armed", 32'(armed), 32'h1);
        check_value("rst_alarm", 32'(alarm_b), 32'h1);
        repeat (3) tick(1'b1, 6'h3F, 1'b0);
        check_value("pre_qual_ff", 32'(ff), 32'h0);
        tick(1'b1, 6'h3F, 1'b0);
        check_value("all_ff", 32'(ff), 32'h3F);
        check_value("all_first", 32'(first_fault), 32'h3F);
        check_value("all_trips", 32'(trip_count), 32'h1);
        clear_and_rearm();
        check_value("rearm_armed", 32'(armed), 32'h1);
        tick(1'b0, '0, 1'b0);

        // glitch rejection on channel 2
        repeat (3) tick(1'b1, 6'h04, 1'b0);
        tick(1'b1, 6'h00, 1'b0);
        repeat (3) tick(1'b1, 6'h04, 1'b0);
        check_value("glitch_ff", 32'(ff), 32'h0);
        tick(1'b1, 6'h04, 1'b0);
        check_value("glitch_trip_ff", 32'(ff), 32'h04);
        check_value("glitch_alarm", 32'(alarm_b), 32'h0);
        check_value("glitch_armed", 32'(armed), 32'h0);
        tick(1'b0, '0, 1'b0);

        // ch4 then ch1, rejected clear, accepted clear, hold-off re-trip
        repeat (10) tick(1'b1, 6'h10, 1'b0);
        repeat (4) tick(1'b1, 6'h12, 1'b0);
        check_value("seq_ff", 32'(ff), 32'h12);
        check_value("seq_first", 32'(first_fault), 32'h10);
        check_value("seq_trips", 32'(trip_count), 32'h1);
        tick(1'b1, 6'h10, 1'b1);
        check_value("nak", 32'(clr_nak), 32'h1);
        tick(1'b1, 6'h10, 1'b0);
        check_value("nak_once", 32'(clr_nak), 32'h0);
        check_value("nak_ff", 32'(ff), 32'h12);
        tick(1'b1, 6'h00, 1'b0);
        tick(1'b1, 6'h00, 1'b1);
        check_value("ack", 32'(clr_ack), 32'h1);
        check_value("ack_ff", 32'(ff), 32'h0);
        tick(1'b1, 6'h01, 1'b0);
        repeat (3) tick(1'b1, 6'h01, 1'b0);
        check_value("ho_ff", 32'(ff), 32'h01);
        check_value("ho_first", 32'(first_fault), 32'h01);
        check_value("ho_trips", 32'(trip_count), 32'h1);
        clear_and_rearm();
        tick(1'b1, '0, 1'b1);
        check_value("armed_clr_ack", 32'(clr_ack), 32'h0);
        check_value("armed_clr_nak", 32'(clr_nak), 32'h0);

        // randomized traffic
        target = '0;
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 29) == 0) begin
                target = ($urandom_range(0, 1) == 0) ? '0 : NF'($urandom);
            end
            drive = target;
            for (int i = 0; i < NF; i++) begin
                if ($urandom_range(0, 11) == 0) drive[i] = ~drive[i];
            end
            tick(($urandom_range(0, 599) != 0), drive, ($urandom_range(0, 5) == 0));
        end

        // saturation of the trip counter
        tick(1'b0, '0, 1'b0);
        for (int n = 0; n < 300; n++) begin
            repeat (DB) tick(1'b1, 6'h01, 1'b0);
            clear_and_rearm();
        end
        check_value("sat_trips", 32'(trip_count), 32'd255);

        // reset in the middle of hold-off
        repeat (DB) tick(1'b1, 6'h20, 1'b0);
        tick(1'b1, '0, 1'b0);
        tick(1'b1, '0, 1'b1);
        repeat (5) tick(1'b1, '0, 1'b0);
        tick(1'b0, '0, 1'b0);
        check_value("mid_rst_trips", 32'(trip_count), 32'h0);
        check_value("mid_rst_armed", 32'(armed), 32'h1);
        check_value("mid_rst_ff", 32'(ff), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
